// File: rtl/gbe_linkup_monitor_if.sv
// Link status bus between the gbe core side (master) and the linkup monitor (slave).
// The master drives the raw linkup and the software clear, and receives the qualified status.
interface gbe_linkup_monitor_if;
    logic        linkup_in;
    logic        cnt_clr;
    logic        link_stable;
    logic        down_event;
    logic [31:0] status_word;

    modport master (
        output linkup_in, cnt_clr,
        input  link_stable, down_event, status_word
    );

    modport slave (
        input  linkup_in, cnt_clr,
        output link_stable, down_event, status_word
    );
endinterface

// File: rtl/gbe_linkup_monitor.sv
// Debounces the raw 10GbE linkup, counts confirmed drops and aborted qualifications,
// and packs everything into the 32-bit status word read by software.
module gbe_linkup_monitor #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int DOWN_CNT_W      = 16,
    parameter int GLITCH_CNT_W    = 8
) (
    input  logic                 user_clk,
    input  logic                 user_rst,
    gbe_linkup_monitor_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        DOWN      = 2'd0,
        QUAL_UP   = 2'd1,
        UP        = 2'd2,
        QUAL_DOWN = 2'd3
    } state_t;

    logic [1:0]              sync_pipe;
    logic                    lk_s;
    state_t                  state;
    logic [DW-1:0]           dcnt;
    logic [DOWN_CNT_W-1:0]   down_cnt;
    logic [GLITCH_CNT_W-1:0] glitch_cnt;
    logic                    ever_down;
    logic                    link_stable_r;
    logic                    down_event_r;
    logic [31:0]             status_r;
    logic                    down_hit;
    logic                    glitch_hit;
    logic                    stable_nxt;

    // linkup_in is asynchronous to user_clk; only the synced copy is used below
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) sync_pipe <= '0;
        else          sync_pipe <= {sync_pipe[0], bus.linkup_in};
    end
    assign lk_s = sync_pipe[1];

    always_comb begin
        down_hit   = (state == QUAL_DOWN) && !lk_s && (dcnt == DLAST);
        glitch_hit = ((state == QUAL_UP) && !lk_s) || ((state == QUAL_DOWN) && lk_s);
        // debounced level: the link counts as up until a drop is fully confirmed
        stable_nxt = 1'b0;
        case (state)
            DOWN:      stable_nxt = 1'b0;
            QUAL_UP:   stable_nxt = lk_s && (dcnt == DLAST);
            UP:        stable_nxt = 1'b1;
            QUAL_DOWN: stable_nxt = !down_hit;
            default:   stable_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state         <= DOWN;
            dcnt          <= '0;
            link_stable_r <= 1'b0;
            down_event_r  <= 1'b0;
        end else begin
            link_stable_r <= stable_nxt;
            down_event_r  <= down_hit;
            case (state)
                DOWN: if (lk_s) begin
                    state <= QUAL_UP;
                    dcnt  <= '0;
                end
                QUAL_UP: begin
                    if (!lk_s)               state <= DOWN;
                    else if (dcnt == DLAST)  state <= UP;
                    else                     dcnt  <= dcnt + 1'b1;
                end
                UP: if (!lk_s) begin
                    state <= QUAL_DOWN;
                    dcnt  <= '0;
                end
                QUAL_DOWN: begin
                    if (lk_s)                state <= UP;
                    else if (dcnt == DLAST)  state <= DOWN;
                    else                     dcnt  <= dcnt + 1'b1;
                end
                default: state <= DOWN;
            endcase
        end
    end

    // a clear coinciding with an event leaves that event counted once
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            down_cnt   <= '0;
            glitch_cnt <= '0;
            ever_down  <= 1'b0;
        end else if (bus.cnt_clr) begin
            down_cnt   <= down_hit   ? DOWN_CNT_W'(1)   : '0;
            glitch_cnt <= glitch_hit ? GLITCH_CNT_W'(1) : '0;
            ever_down  <= down_hit;
        end else begin
            if (down_hit && (down_cnt != '1))     down_cnt   <= down_cnt + 1'b1;
            if (glitch_hit && (glitch_cnt != '1)) glitch_cnt <= glitch_cnt + 1'b1;
            if (down_hit)                         ever_down  <= 1'b1;
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) status_r <= '0;
        else status_r <= {16'(down_cnt), 8'(glitch_cnt), 3'b000, state, ever_down, lk_s,
                          link_stable_r};
    end

    assign bus.link_stable = link_stable_r;
    assign bus.down_event  = down_event_r;
    assign bus.status_word = status_r;
endmodule

// File: tb/tb_gbe_linkup_monitor.sv
// Scoreboard bench: stimulus pushes expected values tagged with a cycle; a negedge
// monitor pops and compares them, and matches every down_event pulse against its queue.
`timescale 1ns/1ps
module tb_gbe_linkup_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gbe_linkup_monitor_if ifa ();
    gbe_linkup_monitor_if ifb ();

    gbe_linkup_monitor #(.DEBOUNCE_CYCLES(4), .DOWN_CNT_W(16), .GLITCH_CNT_W(8)) dut_a (
        .user_clk (clk),
        .user_rst (rst),
        .bus      (ifa.slave)
    );

    // small down counter so saturation is reached within a short run
    gbe_linkup_monitor #(.DEBOUNCE_CYCLES(2), .DOWN_CNT_W(3), .GLITCH_CNT_W(8)) dut_b (
        .user_clk (clk),
        .user_rst (rst),
        .bus      (ifb.slave)
    );

    typedef struct {
        string       name;
        int          cyc;
        int          kind;   // 0: A status, 1: A link_stable, 2: B status
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   dq[$];

    task automatic expect_at(input string name, input int off, input int kind,
                             input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.cyc  = cyc + off;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            case (e.kind)
                0:       act = ifa.status_word;
                1:       act = {31'b0, ifa.link_stable};
                default: act = ifb.status_word;
            endcase
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: check for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                errors++;
                $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.val);
            end
        end
        if (ifa.down_event !== 1'b0) begin
            checks++;
            if (dq.size() > 0 && dq[0] == cyc) void'(dq.pop_front());
            else begin
                errors++;
                $display("FAIL down_event: got %b at cycle %0d, expected 0", ifa.down_event, cyc);
            end
        end
        if (dq.size() > 0 && dq[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL down_event: got no pulse, expected one at cycle %0d", dq[0]);
            void'(dq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ifa.linkup_in = 1'b0; ifa.cnt_clr = 1'b0;
        ifb.linkup_in = 1'b0; ifb.cnt_clr = 1'b0;
        tick(2);
        expect_at("reset_status_a", 0, 0, 32'h0);
        expect_at("reset_stable_a", 0, 1, 32'h0);
        expect_at("reset_status_b", 0, 2, 32'h0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // linkup rises: stable after D+2 edges from the sampling edge
        ifa.linkup_in = 1'b1;
        expect_at("up_stable_early", 6, 1, 32'h0);
        expect_at("up_stable",       7, 1, 32'h1);
        expect_at("up_status_qual",  7, 0, 32'h0000_000A);
        expect_at("up_status",       8, 0, 32'h0000_0013);
        tick(10);

        // 2-cycle glitch while up: no drop, glitch counted
        ifa.linkup_in = 1'b0;
        expect_at("glitch_stable_3", 3, 1, 32'h1);
        expect_at("glitch_stable_4", 4, 1, 32'h1);
        expect_at("glitch_stable_5", 5, 1, 32'h1);
        expect_at("glitch_status",   6, 0, 32'h0000_0113);
        tick(2);
        ifa.linkup_in = 1'b1;
        tick(8);

        ifa.cnt_clr = 1'b1;
        expect_at("clr_status_up", 2, 0, 32'h0000_0013);
        tick(1);
        ifa.cnt_clr = 1'b0;
        tick(3);

        // confirmed drop
        ifa.linkup_in = 1'b0;
        dq.push_back(cyc + 7);
        expect_at("drop_stable_hold", 6, 1, 32'h1);
        expect_at("drop_stable",      7, 1, 32'h0);
        expect_at("drop_status",      8, 0, 32'h0001_0004);
        tick(10);

        ifa.linkup_in = 1'b1;
        expect_at("reup_stable", 7, 1, 32'h1);
        expect_at("reup_status", 8, 0, 32'h0001_0017);
        tick(10);

        ifa.linkup_in = 1'b0;
        expect_at("glitch2_status", 6, 0, 32'h0001_0117);
        tick(2);
        ifa.linkup_in = 1'b1;
        tick(8);

        // clear on the same edge as a confirmed drop
        ifa.linkup_in = 1'b0;
        dq.push_back(cyc + 7);
        expect_at("clr_drop_status", 8, 0, 32'h0001_0004);
        tick(6);
        ifa.cnt_clr = 1'b1;
        tick(1);
        ifa.cnt_clr = 1'b0;
        tick(4);

        ifa.cnt_clr = 1'b1;
        expect_at("clr_only_status", 2, 0, 32'h0000_0000);
        tick(1);
        ifa.cnt_clr = 1'b0;
        tick(3);

        // reset in the middle of a qualification
        ifa.linkup_in = 1'b1;
        tick(4);
        expect_at("qual_status_pre_rst", 0, 0, 32'h0000_000A);
        @(negedge clk);
        #1;
        rst = 1'b1;
        expect_at("rst_mid_status", 1, 0, 32'h0);
        expect_at("rst_mid_stable", 1, 1, 32'h0);
        tick(2);
        rst = 1'b0;
        expect_at("requal_stable_early", 6, 1, 32'h0);
        expect_at("requal_stable",       7, 1, 32'h1);
        expect_at("requal_status",       8, 0, 32'h0000_0013);
        tick(12);

        // down counter saturation on the narrow instance
        for (int i = 0; i < 10; i++) begin
            ifb.linkup_in = 1'b1;
            tick(8);
            ifb.linkup_in = 1'b0;
            tick(8);
            if (i == 5) expect_at("sat_count_6", 0, 2, 32'h0006_0004);
            if (i == 9) expect_at("sat_count_max", 0, 2, 32'h0007_0004);
        end
        tick(3);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        checks++;
        if (dq.size() != 0) begin
            errors++;
            $display("FAIL down_event_drain: got %0d pending, expected 0", dq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
